// File: rtl/dmem_arbiter_if.sv
// Bundle of the requester-side, response and data-memory signals around dmem_arbiter.
// The arbiter uses the slave view; the requesters plus the memory wrapper use the master view.
interface dmem_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [1:0]         req_valid;
  logic [1:0]         req_ready;
  logic [1:0]         req_we;
  logic [3:0]         req_size;
  logic [1:0]         req_unsigned;
  logic [2*WIDTH-1:0] req_addr;
  logic [2*WIDTH-1:0] req_wdata;
  logic [1:0]         resp_valid;
  logic               resp_err;
  logic [WIDTH-1:0]   resp_rdata;
  logic               mem_read;
  logic               mem_write;
  logic [WIDTH-1:0]   mem_addr;
  logic [3:0]         mem_byteen;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem_rdata;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata,
           mem_read, mem_write, mem_addr, mem_byteen, mem_wdata
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata,
           mem_read, mem_write, mem_addr, mem_byteen, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core (port 0) and debug/DMA (port 1),
// with alignment checking, byte-lane mapping of stores and extension of returned load data.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter bit RST_PRIO = 1'b0
) (
  input logic           clk,
  input logic           rst_n,
  dmem_arbiter_if.slave bus
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  logic             last_grant;
  logic             grant_any;
  logic             grant_port;
  logic             sel_we;
  logic             sel_unsigned;
  logic [1:0]       sel_size;
  logic [1:0]       sel_off;
  logic [WIDTH-1:0] sel_addr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_err;
  logic [3:0]       base_en;

  logic             pend_valid;
  logic             pend_port;
  logic             pend_unsigned;
  logic             pend_we;
  logic             pend_err;
  logic [1:0]       pend_size;
  logic [1:0]       pend_off;

  logic [WIDTH-1:0] rdata_shift;
  logic [WIDTH-1:0] rdata_ext;
  logic             sign_bit;

  // Under contention the port that did not win last time gets the slot.
  always_comb begin
    grant_any  = rst_n && (bus.req_valid != 2'b00);
    grant_port = 1'b0;
    case (bus.req_valid)
      2'b01:   grant_port = 1'b0;
      2'b10:   grant_port = 1'b1;
      2'b11:   grant_port = ~last_grant;
      default: grant_port = 1'b0;
    endcase
  end

  always_comb begin
    sel_we       = bus.req_we[grant_port];
    sel_unsigned = bus.req_unsigned[grant_port];
    sel_size     = grant_port ? bus.req_size[3:2] : bus.req_size[1:0];
    sel_addr     = grant_port ? bus.req_addr[2*WIDTH-1:WIDTH] : bus.req_addr[WIDTH-1:0];
    sel_wdata    = grant_port ? bus.req_wdata[2*WIDTH-1:WIDTH] : bus.req_wdata[WIDTH-1:0];
    sel_off      = sel_addr[1:0];
    sel_err      = 1'b1;
    base_en      = 4'b0000;
    case (sel_size)
      SIZE_BYTE: begin sel_err = 1'b0;               base_en = 4'b0001; end
      SIZE_HALF: begin sel_err = sel_off[0];         base_en = 4'b0011; end
      SIZE_WORD: begin sel_err = (sel_off != 2'b00); base_en = 4'b1111; end
      default:   begin sel_err = 1'b1;               base_en = 4'b0000; end
    endcase
  end

  // Erroneous requests are still accepted but never reach the memory.
  always_comb begin
    bus.req_ready  = 2'b00;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_byteen = 4'b0000;
    bus.mem_wdata  = '0;
    if (grant_any) begin
      bus.req_ready = grant_port ? 2'b10 : 2'b01;
      if (!sel_err) begin
        bus.mem_read   = ~sel_we;
        bus.mem_write  = sel_we;
        bus.mem_addr   = {sel_addr[WIDTH-1:2], 2'b00};
        bus.mem_byteen = base_en << sel_off;
        bus.mem_wdata  = sel_wdata << {sel_off, 3'b000};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= ~RST_PRIO;
      pend_valid    <= 1'b0;
      pend_port     <= 1'b0;
      pend_unsigned <= 1'b0;
      pend_we       <= 1'b0;
      pend_err      <= 1'b0;
      pend_size     <= 2'b00;
      pend_off      <= 2'b00;
    end else begin
      pend_valid <= grant_any;
      if (grant_any) begin
        last_grant    <= grant_port;
        pend_port     <= grant_port;
        pend_unsigned <= sel_unsigned;
        pend_we       <= sel_we;
        pend_err      <= sel_err;
        pend_size     <= sel_size;
        pend_off      <= sel_off;
      end
    end
  end

  // The memory word arrives one cycle after the strobe; extract the addressed lanes and extend.
  always_comb begin
    rdata_shift = bus.mem_rdata >> {pend_off, 3'b000};
    sign_bit    = 1'b0;
    rdata_ext   = rdata_shift;
    case (pend_size)
      SIZE_BYTE: begin
        sign_bit  = ~pend_unsigned & rdata_shift[7];
        rdata_ext = {{(WIDTH-8){sign_bit}}, rdata_shift[7:0]};
      end
      SIZE_HALF: begin
        sign_bit  = ~pend_unsigned & rdata_shift[15];
        rdata_ext = {{(WIDTH-16){sign_bit}}, rdata_shift[15:0]};
      end
      default: rdata_ext = rdata_shift;
    endcase
  end

  always_comb begin
    bus.resp_valid = 2'b00;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = '0;
    if (pend_valid) begin
      bus.resp_valid = pend_port ? 2'b10 : 2'b01;
      bus.resp_err   = pend_err;
      if (!pend_we && !pend_err) begin
        bus.resp_rdata = rdata_ext;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-array reference model predicts grants, memory strobes
// and responses; a separate monitor pops expected responses whenever resp_valid is seen.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          port;
    logic        err;
    logic [31:0] rdata;
    int          due;
  } resp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   assertions = 0;
  int   failures   = 0;

  req_t  port_q0[$];
  req_t  port_q1[$];
  resp_t sb[$];

  logic [7:0]  model_bytes[256];
  logic [31:0] mem_words[64];
  int          model_last = 1;
  int          last_win   = 0;

  logic        obs_read, obs_write;
  logic [3:0]  obs_byteen;
  logic [31:0] obs_addr, obs_wdata;
  int          last_resp_port = -1;
  logic        last_resp_err  = 1'b0;
  logic [31:0] last_resp_rdata = '0;

  logic        cap_read, cap_write;
  logic [5:0]  cap_idx;
  logic [3:0]  cap_en;
  logic [31:0] cap_wdata;

  dmem_arbiter_if #(.WIDTH(32)) bus ();

  dmem_arbiter #(.WIDTH(32), .RST_PRIO(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Memory wrapper stand-in: strobes captured mid-cycle, applied on the following rising edge.
  always @(negedge clk) begin
    cap_read  = bus.mem_read;
    cap_write = bus.mem_write;
    cap_idx   = bus.mem_addr[7:2];
    cap_en    = bus.mem_byteen;
    cap_wdata = bus.mem_wdata;
  end

  always @(posedge clk) begin
    bus.mem_rdata <= cap_read ? mem_words[cap_idx] : $urandom;
    if (cap_write) begin
      for (int b = 0; b < 4; b++) begin
        if (cap_en[b]) mem_words[cap_idx][8*b +: 8] = cap_wdata[8*b +: 8];
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic is_err(input req_t r);
    if (r.size == 2'b11) return 1'b1;
    return (int'(r.addr[1:0]) % nbytes(r.size)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input req_t r);
    logic [63:0] v;
    int n;
    v = '0;
    n = nbytes(r.size);
    for (int i = 0; i < n; i++) v = v | (64'(model_bytes[8'(r.addr + 32'(i))]) << (8 * i));
    if (!r.uns && n < 4 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v[31:0];
  endfunction

  function automatic void model_store(input req_t r);
    for (int i = 0; i < nbytes(r.size); i++) model_bytes[8'(r.addr + 32'(i))] = r.wdata[8*i +: 8];
  endfunction

  function automatic void set_word(input logic [7:0] addr, input logic [31:0] val);
    mem_words[addr[7:2]] = val;
    for (int i = 0; i < 4; i++) model_bytes[{addr[7:2], 2'(i)}] = val[8*i +: 8];
  endfunction

  function automatic req_t mk_req(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.size = size; r.uns = uns; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.uns   = 1'($urandom_range(0, 1));
    r.size  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
    r.addr  = 32'($urandom_range(0, 255));
    r.wdata = $urandom;
    if ($urandom_range(0, 3) != 0 && r.size != 2'b11) r.addr = r.addr & ~32'(nbytes(r.size) - 1);
    return r;
  endfunction

  // One clock cycle: present queue heads, predict the winner and memory strobes, queue the response.
  task automatic apply_stimulus();
    req_t  h0, h1, r;
    logic  v0, v1, e;
    int    win;
    resp_t x;
    v0 = (port_q0.size() > 0);
    v1 = (port_q1.size() > 0);
    h0 = v0 ? port_q0[0] : rand_req();
    h1 = v1 ? port_q1[0] : rand_req();
    bus.req_valid    = {v1, v0};
    bus.req_we       = {h1.we, h0.we};
    bus.req_size     = {h1.size, h0.size};
    bus.req_unsigned = {h1.uns, h0.uns};
    bus.req_addr     = {h1.addr, h0.addr};
    bus.req_wdata    = {h1.wdata, h0.wdata};
    @(negedge clk);
    obs_read   = bus.mem_read;
    obs_write  = bus.mem_write;
    obs_byteen = bus.mem_byteen;
    obs_addr   = bus.mem_addr;
    obs_wdata  = bus.mem_wdata;
    win = (v0 && v1) ? (1 - model_last) : (v1 ? 1 : 0);
    check_output("req_ready", 32'(bus.req_ready), (v0 || v1) ? 32'(1 << win) : 32'd0);
    if (v0 || v1) begin
      r = win ? h1 : h0;
      last_win   = win;
      model_last = win;
      e = is_err(r);
      if (!e) begin
        check_output("mem_read",   32'(obs_read),  32'(!r.we));
        check_output("mem_write",  32'(obs_write), 32'(r.we));
        check_output("mem_addr",   obs_addr, r.addr & 32'hFFFF_FFFC);
        check_output("mem_byteen", 32'(obs_byteen), 32'(((1 << nbytes(r.size)) - 1) << r.addr[1:0]));
        check_output("mem_wdata",  obs_wdata, r.wdata << (8 * r.addr[1:0]));
      end else begin
        check_output("err_strobes", 32'({obs_read, obs_write, obs_byteen}), 32'd0);
      end
      x.port  = win;
      x.err   = e;
      x.rdata = (e || r.we) ? 32'd0 : model_load(r);
      x.due   = cycle + 1;
      sb.push_back(x);
      if (!e && r.we) model_store(r);
      if (win == 1) void'(port_q1.pop_front());
      else          void'(port_q0.pop_front());
    end else begin
      check_output("idle_mem", 32'({obs_read, obs_write, obs_byteen}) | obs_addr | obs_wdata, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    resp_t e;
    if (rst_n) begin
      if (bus.resp_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check_output("resp_unexpected", 32'(bus.resp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          last_resp_port  = e.port;
          last_resp_err   = bus.resp_err;
          last_resp_rdata = bus.resp_rdata;
          check_output("resp_valid", 32'(bus.resp_valid), 32'(1 << e.port));
          check_output("resp_err",   32'(bus.resp_err), 32'(e.err));
          check_output("resp_rdata", bus.resp_rdata, e.rdata);
          check_output("resp_cycle", 32'(cycle), 32'(e.due));
        end
      end else if (sb.size() != 0 && sb[0].due <= cycle) begin
        e = sb.pop_front();
        check_output("resp_missing", 32'(bus.resp_valid), 32'(1 << e.port));
      end
    end
  end

  task automatic check_all_zero(input string name);
    check_output({name, "_ready"}, 32'(bus.req_ready), 32'd0);
    check_output({name, "_resp"}, 32'({bus.resp_valid, bus.resp_err}) | bus.resp_rdata, 32'd0);
    check_output({name, "_mem"}, 32'({bus.mem_read, bus.mem_write, bus.mem_byteen}) | bus.mem_addr | bus.mem_wdata, 32'd0);
  endtask

  initial begin
    int grants[4];
    bus.req_valid = 2'b00; bus.req_we = 2'b00; bus.req_size = 4'h0; bus.req_unsigned = 2'b00;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) set_word(8'(i * 4), $urandom);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 2; i++) begin
      port_q0.push_back(mk_req(1'b0, 2'b10, 1'b0, 32'h40, 32'h0));
      port_q1.push_back(mk_req(1'b0, 2'b10, 1'b0, 32'h44, 32'h0));
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus();
      grants[i] = last_win;
    end
    check_output("contention_order", 32'({grants[0][0], grants[1][0], grants[2][0], grants[3][0]}), 32'b0101);
    apply_stimulus();

    set_word(8'h10, 32'hDEADBEEF);
    port_q0.push_back(mk_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
    apply_stimulus();
    check_output("lw_byteen", 32'(obs_byteen), 32'hF);
    check_output("lw_addr", obs_addr, 32'h10);
    apply_stimulus();
    check_output("lw_rdata", last_resp_rdata, 32'hDEADBEEF);

    set_word(8'h10, 32'h80123456);
    port_q0.push_back(mk_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0));
    apply_stimulus();
    check_output("lb_byteen", 32'(obs_byteen), 32'b1000);
    port_q0.push_back(mk_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0));
    apply_stimulus();
    check_output("lb_rdata", last_resp_rdata, 32'hFFFFFF80);
    apply_stimulus();
    check_output("lbu_rdata", last_resp_rdata, 32'h00000080);

    port_q1.push_back(mk_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD));
    apply_stimulus();
    check_output("sh_byteen", 32'(obs_byteen), 32'b1100);
    check_output("sh_wdata", obs_wdata, 32'hABCD0000);
    apply_stimulus();
    check_output("sh_port", 32'(last_resp_port), 32'd1);

    port_q0.push_back(mk_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0));
    port_q0.push_back(mk_req(1'b0, 2'b11, 1'b0, 32'h08, 32'h0));
    apply_stimulus();
    apply_stimulus();
    check_output("lw_mis_err", 32'(last_resp_err), 32'd1);
    apply_stimulus();
    check_output("size11_err", 32'(last_resp_err), 32'd1);

    port_q0.push_back(mk_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
    apply_stimulus();
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    sb.delete();
    model_last = 1;
    @(negedge clk);
    check_all_zero("midreset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    port_q0.push_back(mk_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0));
    apply_stimulus();
    apply_stimulus();
    check_output("post_reset_rdata", last_resp_rdata, 32'h80123456);

    for (int c = 0; c < 400; c++) begin
      if (port_q0.size() == 0 && $urandom_range(0, 9) < 6) port_q0.push_back(rand_req());
      if (port_q1.size() == 0 && $urandom_range(0, 9) < 6) port_q1.push_back(rand_req());
      apply_stimulus();
    end
    port_q0.delete();
    port_q1.delete();
    repeat (3) apply_stimulus();
    check_output("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
